// File: rtl/bram_port_server.sv
// bram_port_server: valid/ready request front end for one port of a write-first
// byte-enable BRAM. Drives the BRAM pins combinationally on accept, tracks the fixed
// read latency, and captures DO into a credit-protected response FIFO.
module bram_port_server #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WE_WIDTH      = 4,
    parameter int unsigned PIPELINED     = 0,
    parameter int unsigned RESP_DEPTH    = 4,
    parameter int unsigned RESP_ON_WRITE = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [WE_WIDTH-1:0]   REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    output logic                  RESP_VALID,
    input  logic                  RESP_READY,
    output logic [DATA_WIDTH-1:0] RESP_DATA,
    output logic                  BRAM_EN,
    output logic [WE_WIDTH-1:0]   BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DI,
    input  logic [DATA_WIDTH-1:0] BRAM_DO
);

    localparam int unsigned Lat   = 1 + PIPELINED;
    localparam int unsigned IdxW  = $clog2(RESP_DEPTH);
    localparam int unsigned PtrW  = IdxW + 1;
    localparam int unsigned CredW = $clog2(RESP_DEPTH + 1);

    logic                  accept;
    logic                  needs_resp;
    logic                  claim;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic [CredW-1:0]      credits_q, credits_d;
    logic [Lat-1:0]        track_q, track_d;
    logic [PtrW-1:0]       wptr_q, rptr_q;
    logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];

    // Handshake, BRAM pin drive and FIFO status.
    always_comb begin
        REQ_READY  = (credits_q != '0) && !RST;
        accept     = REQ_VALID && REQ_READY;
        needs_resp = (REQ_WE == '0) || (RESP_ON_WRITE != 0);
        claim      = accept && needs_resp;
        empty      = (wptr_q == rptr_q);
        RESP_VALID = !empty;
        RESP_DATA  = mem_q[rptr_q[IdxW-1:0]];
        pop        = RESP_VALID && RESP_READY;
        push       = track_q[Lat-1];
        BRAM_EN    = accept;
        BRAM_WE    = accept ? REQ_WE : '0;
        BRAM_ADDR  = REQ_ADDR;
        BRAM_DI    = REQ_DATA;
    end

    // Credits reserve a FIFO slot at accept time so a BRAM output is never dropped.
    always_comb begin
        credits_d = credits_q;
        if (claim && !pop) begin
            credits_d = credits_q - CredW'(1);
        end else if (pop && !claim) begin
            credits_d = credits_q + CredW'(1);
        end
    end

    // Response-expected bits follow the BRAM read latency; shifts every cycle.
    always_comb begin
        track_d    = track_q << 1;
        track_d[0] = claim;
    end

    // Credit counter and in-flight tracker state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            credits_q <= CredW'(RESP_DEPTH);
            track_q   <= '0;
        end else begin
            credits_q <= credits_d;
            track_q   <= track_d;
        end
    end

    // Response FIFO: storage cleared on reset, wrap bit separates full from empty.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(RESP_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wptr_q[IdxW-1:0]] <= BRAM_DO;
                wptr_q                  <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
        end
    end

endmodule
